// File: rtl/aes128_cbc_sequencer.sv
// aes128_cbc_sequencer: CBC-mode encryption front end for an iterative AES-128 core
module aes128_cbc_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         iv_load,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         busy,
    output logic         err,
    output logic         core_rst_n,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    output logic         core_is_decrypt,
    input  logic [127:0] core_out,
    input  logic         core_ready
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t        r_state, w_next;
    logic [127:0]  r_chain, r_in, r_key, r_out;
    logic [TW-1:0] r_tcnt;
    logic          r_err;
    logic          w_iv_take, w_accept, w_done, w_tmo;

    assign w_iv_take = r_state == IDLE && iv_load;
    assign w_accept  = r_state == IDLE && !iv_load && s_valid;
    assign w_done    = r_state == RUN && core_ready;
    assign w_tmo     = r_state == RUN && !core_ready && r_tcnt == TW'(TIMEOUT - 1);

    assign core_in         = r_in;
    assign core_key        = r_key;
    assign core_is_decrypt = 1'b0;
    assign err             = r_err;
    assign m_data          = reset_n ? r_out : '0;

    // state register
    always_ff @(posedge clk) begin
        r_state <= !reset_n ? IDLE : w_next;
    end

    // next state plus stream handshakes and core reset; all quiet while in reset
    always_comb begin
        w_next     = r_state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        core_rst_n = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = !iv_load;
                w_next  = w_accept ? LOAD : IDLE;
            end
            LOAD: begin
                busy   = 1'b1;
                w_next = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                core_rst_n = 1'b1;
                w_next     = core_ready ? OUT : (w_tmo ? IDLE : RUN);
            end
            OUT: begin
                busy       = 1'b1;
                core_rst_n = 1'b1;
                m_valid    = 1'b1;
                w_next     = m_ready ? IDLE : OUT;
            end
            default: w_next = IDLE;
        endcase
        if (!reset_n) begin
            s_ready    = 1'b0;
            m_valid    = 1'b0;
            busy       = 1'b0;
            core_rst_n = 1'b0;
        end
    end

    // chain value, core operands, captured ciphertext, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_chain <= '0;
            r_in    <= '0;
            r_key   <= '0;
            r_out   <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_iv_take) r_chain <= iv;
            if (w_accept) begin
                r_in  <= s_data ^ r_chain;
                r_key <= key;
            end
            if (r_state == LOAD) r_tcnt <= '0;
            else if (r_state == RUN && !core_ready) r_tcnt <= r_tcnt + 1'b1;
            if (w_done) begin
                r_out   <= core_out;
                r_chain <= core_out;
            end
            if (w_tmo) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes128_cbc_sequencer.sv
// tb_aes128_cbc_sequencer: CBC sequencer bench with a behavioural AES core and CBC reference model
module tb_aes128_cbc_sequencer;
    localparam int TIMEOUT = 32;

    logic         clk = 1'b0, reset_n = 1'b0, iv_load = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [127:0] key = '0, iv = '0, s_data = '0;
    logic         s_ready, m_valid, busy, err, core_rst_n, core_is_decrypt, core_ready;
    logic [127:0] m_data, core_in, core_key, core_out;
    logic         stall = 1'b0, err_exp = 1'b0;
    logic [3:0]   ccnt = '0;
    logic [127:0] mchain = '0;
    int           checks = 0, errors = 0;

    aes128_cbc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .iv(iv), .iv_load(iv_load),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err), .core_rst_n(core_rst_n), .core_in(core_in),
        .core_key(core_key), .core_is_decrypt(core_is_decrypt),
        .core_out(core_out), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0]  r;
        logic [15:0] d;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gm(r, r);
            if (i > 0) r = gm(r, x);
        end
        d = {r, r};
        return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] rk[176];
        logic [7:0] w0, w1, w2, w3, rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[8*i +: 8];
            s[i]  = pt[8*i +: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            w0 = rk[i-4]; w1 = rk[i-3]; w2 = rk[i-2]; w3 = rk[i-1];
            if (i % 16 == 0) begin
                w0 = sb(rk[i-3]) ^ rc; w1 = sb(rk[i-2]); w2 = sb(rk[i-1]); w3 = sb(rk[i-4]);
                rc = xt(rc);
            end
            rk[i] = rk[i-16] ^ w0; rk[i+1] = rk[i-15] ^ w1;
            rk[i+2] = rk[i-14] ^ w2; rk[i+3] = rk[i-13] ^ w3;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[i % 4 + 4 * ((i / 4 + i % 4) % 4)]);
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c], 8'd2) ^ gm(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'd2) ^ gm(t[4*c+2], 8'd3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'd2) ^ gm(t[4*c+3], 8'd3);
                    s[4*c+3] = gm(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'd2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // core model: operands latched while parked, ready after 12 running edges
    always @(posedge clk) ccnt <= !core_rst_n ? 4'd0 : (ccnt == 4'd12 ? ccnt : ccnt + 4'd1);
    assign core_ready = !stall && ccnt == 4'd12;
    assign core_out   = aes_enc(core_in, core_key);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv = v;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        #1;
        mchain = v;
    endtask

    task automatic accept(input logic [127:0] p, input logic [127:0] k, output int w);
        w = 0;
        while (!s_ready && w < 50) begin
            tick();
            w++;
        end
        chk1("s_ready_idle", s_ready, 1'b1);
        s_valid = 1'b1;
        s_data = p;
        key = k;
        tick();
        s_valid = 1'b0;
        s_data = rnd();
        key = rnd();
    endtask

    task automatic blk(input logic [127:0] p, input logic [127:0] k, input int hold,
                       input bit ivp, input bit b2b, output logic [127:0] got);
        logic [127:0] exp;
        int w, lat;
        exp = aes_enc(p ^ mchain, k);
        accept(p, k, w);
        if (b2b) chk("b2b_wait", 128'(w), 128'(0));
        chk1("s_ready_busy", s_ready, 1'b0);
        chk1("busy_run", busy, 1'b1);
        lat = 1;
        while (!m_valid && lat < 60) begin
            if (ivp && lat == 4) begin
                iv_load = 1'b1;
                iv = rnd();
            end else iv_load = 1'b0;
            tick();
            lat++;
        end
        iv_load = 1'b0;
        #1;
        chk1("m_valid_rise", m_valid, 1'b1);
        chk("latency", 128'(lat), 128'(15));
        chk1("excl_sready", s_ready, 1'b0);
        got = m_data;
        chk("cbc_data", m_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_data", m_data, got);
            chk1("hold_valid", m_valid, 1'b1);
            chk1("hold_sready", s_ready, 1'b0);
            chk1("hold_err", err, err_exp);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk1("m_valid_drop", m_valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        mchain = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got, p, k, v, sv;
        int n, w;
        bit saw;
        tick();
        tick();
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_core_rst_n", core_rst_n, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk1("is_decrypt", core_is_decrypt, 1'b0);
        reset_n = 1'b1;
        tick();

        load_iv('0);
        blk(bswap(128'h00112233445566778899aabbccddeeff), bswap(128'h000102030405060708090a0b0c0d0e0f), 0, 0, 0, got);
        chk("fips197", got, bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

        load_iv(bswap(128'h000102030405060708090a0b0c0d0e0f));
        k = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        blk(bswap(128'h6bc1bee22e409f96e93d7e117393172a), k, 0, 0, 0, got);
        chk("sp800_blk1", got, bswap(128'h7649abac8119b246cee98e9b12e9197d));
        blk(bswap(128'hae2d8a571e03ac9c9eb76fac45af8e51), k, 0, 0, 1, got);
        chk("sp800_blk2", got, bswap(128'h5086cb9b507219ee95db113a917678b2));

        blk(rnd(), rnd(), 20, 0, 0, got);

        p = rnd();
        k = rnd();
        v = rnd();
        iv = v;
        iv_load = 1'b1;
        s_valid = 1'b1;
        s_data = p;
        key = k;
        #1;
        chk1("ivload_sready", s_ready, 1'b0);
        tick();
        iv_load = 1'b0;
        #1;
        chk1("ivload_no_accept", busy, 1'b0);
        mchain = v;
        blk(p, k, 0, 1, 1, got);
        blk(rnd(), rnd(), 0, 0, 0, got);

        sv = mchain;
        stall = 1'b1;
        accept(rnd(), rnd(), w);
        tick();
        n = 0;
        saw = 1'b0;
        while (!err && n < 100) begin
            tick();
            n++;
            saw |= m_valid;
        end
        chk("timeout_cycles", 128'(n), 128'(TIMEOUT));
        chk1("timeout_err", err, 1'b1);
        chk1("timeout_idle", busy, 1'b0);
        chk1("timeout_no_out", saw, 1'b0);
        stall = 1'b0;
        err_exp = 1'b1;
        mchain = sv;
        blk(rnd(), rnd(), 2, 0, 0, got);
        chk1("err_sticky", err, 1'b1);

        accept(rnd(), rnd(), w);
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_m_valid", m_valid, 1'b0);
        chk1("mid_rst_core_rst_n", core_rst_n, 1'b0);
        chk1("mid_rst_s_ready", s_ready, 1'b0);
        chk("mid_rst_m_data", m_data, '0);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            saw |= m_valid;
        end
        chk1("post_rst_no_out", saw, 1'b0);
        chk1("post_rst_err", err, 1'b0);
        err_exp = 1'b0;
        mchain = '0;
        blk(rnd(), rnd(), 0, 0, 0, got);

        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) load_iv(rnd());
            blk(rnd(), rnd(), int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1, 1'b0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
